// File: rtl/logic_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : logic_seq_unit
// Purpose  : Multi-cycle bitwise / bit-counting unit for the ALU. Operands are
//            captured on a valid/ready handshake and processed SLICE bits per
//            cycle, MSB slice first. The result is held until it is taken.
//            Functions: AND, OR, XOR, NOR, PASS_A, CLZ, POPCNT. Any other
//            code returns S = 1 with err = 1 after the same latency.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            in_valid_i/in_ready_o   - operand handshake (ready only in IDLE)
//            a_i, b_i, ft_i    - operands and 4-bit function code
//            abort_i           - synchronous cancel, highest priority
//            out_valid_o/out_ready_i - result handshake
//            s_o, err_o        - result and illegal-code flag
// Revision : 1.0 - initial release
// ============================================================================
module logic_seq_unit #(
  parameter int WIDTH = 32,  // must be a multiple of SLICE
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       ft_i,
  input  logic             abort_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             err_o
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = $clog2(WIDTH + 1);
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  localparam logic [3:0] FT_AND  = 4'b1000;
  localparam logic [3:0] FT_OR   = 4'b1110;
  localparam logic [3:0] FT_XOR  = 4'b0110;
  localparam logic [3:0] FT_NOR  = 4'b0001;
  localparam logic [3:0] FT_PASS = 4'b1010;
  localparam logic [3:0] FT_CLZ  = 4'b0011;
  localparam logic [3:0] FT_POP  = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [3:0] f);
    case (f)
      FT_AND, FT_OR, FT_XOR, FT_NOR, FT_PASS, FT_CLZ, FT_POP: is_legal = 1'b1;
      default:                                                is_legal = 1'b0;
    endcase
  endfunction

  state_t           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] opa_q;      // shifted left one slice per RUN cycle
  logic [WIDTH-1:0] opb_q;
  logic [3:0]       ft_q;
  logic             err_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] res_q;      // bitwise result under construction
  logic [CW-1:0]    acc_q;      // CLZ / POPCNT accumulator
  logic             found_q;    // CLZ: a 1 has been seen in an earlier slice

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] r_sl;
  logic [CW-1:0]    sl_clz;
  logic [CW-1:0]    sl_pop;
  logic             sl_seen;
  logic [CW-1:0]    acc_d;
  logic             found_d;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] fin_d;

  // Current slice is always the top SLICE bits of the shifting operand copies.
  always_comb begin
    a_sl = opa_q[WIDTH-1 -: SLICE];
    b_sl = opb_q[WIDTH-1 -: SLICE];

    case (ft_q)
      FT_AND:  r_sl = a_sl & b_sl;
      FT_OR:   r_sl = a_sl | b_sl;
      FT_XOR:  r_sl = a_sl ^ b_sl;
      FT_NOR:  r_sl = ~(a_sl | b_sl);
      FT_PASS: r_sl = a_sl;
      default: r_sl = '0;
    endcase

    sl_clz  = '0;
    sl_pop  = '0;
    sl_seen = 1'b0;
    for (int i = SLICE - 1; i >= 0; i--) begin
      if (a_sl[i]) begin
        sl_pop  = sl_pop + CW'(1);
        sl_seen = 1'b1;
      end else if (!sl_seen) begin
        sl_clz = sl_clz + CW'(1);
      end
    end
  end

  always_comb begin
    acc_d   = acc_q;
    found_d = found_q;
    if (ft_q == FT_CLZ) begin
      // Once a 1 has appeared, lower slices contribute no leading zeros.
      if (!found_q) begin
        acc_d = acc_q + sl_clz;
      end
      found_d = found_q | sl_seen;
    end else if (ft_q == FT_POP) begin
      acc_d = acc_q + sl_pop;
    end

    // MSB slice enters first, so shifting left places every slice at its own
    // bit position once the last one is in.
    res_d = (res_q << SLICE) | WIDTH'(r_sl);

    if (err_q) begin
      fin_d = WIDTH'(1);
    end else if ((ft_q == FT_CLZ) || (ft_q == FT_POP)) begin
      fin_d = WIDTH'(acc_d);
    end else begin
      fin_d = res_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      ft_q        <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      res_q       <= '0;
      acc_q       <= '0;
      found_q     <= 1'b0;
    end else if (abort_i) begin
      // S deliberately keeps the last delivered result.
      state_q     <= ST_IDLE;
      k_q         <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      found_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            opa_q      <= a_i;
            opb_q      <= b_i;
            ft_q       <= ft_i;
            err_q      <= !is_legal(ft_i);
            k_q        <= '0;
            res_q      <= '0;
            acc_q      <= '0;
            found_q    <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          opa_q   <= opa_q << SLICE;
          opb_q   <= opb_q << SLICE;
          res_q   <= res_d;
          acc_q   <= acc_d;
          found_q <= found_d;
          k_q     <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            s_q         <= fin_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            k_q         <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign s_o         = s_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_seq_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_logic_seq_unit
// Purpose  : Self-checking bench for logic_seq_unit. A latency/handshake
//            model of the 32/8 unit is compared every cycle; directed vectors
//            with literal results pin the model. 64/16 and 32/32 instances
//            cover other geometries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_seq_unit;

  localparam logic [3:0] F_AND  = 4'b1000;
  localparam logic [3:0] F_OR   = 4'b1110;
  localparam logic [3:0] F_XOR  = 4'b0110;
  localparam logic [3:0] F_NOR  = 4'b0001;
  localparam logic [3:0] F_PASS = 4'b1010;
  localparam logic [3:0] F_CLZ  = 4'b0011;
  localparam logic [3:0] F_POP  = 4'b0101;
  localparam logic [3:0] F_BAD  = 4'b1111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32/8 unit under main test
  logic        in_valid, in_ready, abort, out_valid, out_ready, err;
  logic [31:0] a, b, s;
  logic [3:0]  ft;

  // Shared stimulus for the 64/16 and 32/32 units
  logic        x_valid, x_ready, x_abort;
  logic [63:0] x_a, x_b;
  logic [3:0]  x_ft;
  logic        rdy64, v64, e64, rdy1, v1, e1;
  logic [63:0] s64;
  logic [31:0] s1;

  logic_seq_unit #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .ft_i(ft), .abort_i(abort),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .s_o(s), .err_o(err)
  );

  logic_seq_unit #(.WIDTH(64), .SLICE(16)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(x_valid), .in_ready_o(rdy64),
    .a_i(x_a), .b_i(x_b), .ft_i(x_ft), .abort_i(x_abort),
    .out_valid_o(v64), .out_ready_i(x_ready),
    .s_o(s64), .err_o(e64)
  );

  logic_seq_unit #(.WIDTH(32), .SLICE(32)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(x_valid), .in_ready_o(rdy1),
    .a_i(x_a[31:0]), .b_i(x_b[31:0]), .ft_i(x_ft), .abort_i(x_abort),
    .out_valid_o(v1), .out_ready_i(x_ready),
    .s_o(s1), .err_o(e1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result {err, S} from the function definitions for a w-bit unit.
  function automatic logic [64:0] ref_op(input int w, input logic [3:0] f,
                                         input logic [63:0] x, input logic [63:0] y);
    logic [63:0] m;
    logic [63:0] r;
    logic        e;
    int          n;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    e = 1'b0;
    n = 0;
    case (f)
      F_AND:  r = x & y;
      F_OR:   r = x | y;
      F_XOR:  r = x ^ y;
      F_NOR:  r = ~(x | y);
      F_PASS: r = x;
      F_CLZ: begin
        while (n < w && !x[w-1-n]) n++;
        r = 64'(n);
      end
      F_POP:  r = 64'($countones(x & m));
      default: begin
        r = 64'd1;
        e = 1'b1;
      end
    endcase
    return {e, r & m};
  endfunction

  // Transaction model: result appears 4 edges after acceptance, held until taken.
  logic        m_busy, m_valid, m_err;
  logic [31:0] m_s;
  logic [64:0] p_res;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      m_s     <= '0;
      p_res   <= '0;
      m_cnt   <= 0;
    end else if (abort) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 4;
        p_res  <= ref_op(32, ft, {32'd0, a}, {32'd0, b});
      end
    end else if (!m_valid) begin
      if (m_cnt == 1) begin
        m_valid <= 1'b1;
        m_s     <= p_res[31:0];
        m_err   <= p_res[64];
      end
      m_cnt <= m_cnt - 1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", {63'd0, in_ready}, {63'd0, !m_busy});
      check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      if (m_valid) begin
        check("model S", {32'd0, s}, {32'd0, m_s});
        check("model err", {63'd0, err}, {63'd0, m_err});
      end
    end
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] ift);
    @(posedge clk); #1;
    a = ia; b = ib; ft = ift; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; ft = 4'b0000;  // must not affect the result
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp, input logic exp_e);
    int lat;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check({name, " latency"}, 64'(lat), 64'd4);
    check(name, {32'd0, s}, {32'd0, exp});
    check({name, " err"}, {63'd0, err}, {63'd0, exp_e});
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input string name, input logic [31:0] ia, input logic [31:0] ib,
                     input logic [3:0] ift, input logic [31:0] exp, input logic exp_e);
    issue(ia, ib, ift);
    wait_valid(name, exp, exp_e);
    take();
  endtask

  task automatic aux_op(input string name, input logic [63:0] xa, input logic [3:0] xf,
                        input logic [63:0] e64_s, input logic [31:0] e1_s);
    int c, l64, l1;
    c = 0; l64 = -1; l1 = -1;
    @(posedge clk); #1;
    x_a = xa; x_ft = xf; x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0; x_a = {$urandom, $urandom};
    while ((l64 < 0 || l1 < 0) && c < 20) begin
      @(negedge clk);
      if (v64 && l64 < 0) begin
        l64 = c;
        check({name, " w64"}, s64, e64_s);
        check({name, " w64 err"}, {63'd0, e64}, 64'd0);
      end
      if (v1 && l1 < 0) begin
        l1 = c;
        check({name, " w32s32"}, {32'd0, s1}, {32'd0, e1_s});
        check({name, " w32s32 err"}, {63'd0, e1}, 64'd0);
      end
      c++;
    end
    check({name, " w64 latency"}, 64'(l64), 64'd4);
    check({name, " w32s32 latency"}, 64'(l1), 64'd1);
    x_ready = 1'b1;
    @(posedge clk); #1;
    x_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; a = '0; b = '0; ft = '0; abort = 1'b0; out_ready = 1'b0;
    x_valid = 1'b0; x_ready = 1'b0; x_abort = 1'b0; x_a = '0; x_b = '0; x_ft = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset S", {32'd0, s}, 64'd0);
    check("reset err", {63'd0, err}, 64'd0);
    check("reset w64 out_valid", {63'd0, v64}, 64'd0);

    run("AND", 32'hF0F0_1234, 32'h0FF0_FFFF, F_AND, 32'h00F0_1234, 1'b0);

    run("OR",     32'hDEAD_BEEF, 32'h1234_5678, F_OR,   32'hDEBD_FEFF, 1'b0);
    run("XOR",    32'hDEAD_BEEF, 32'h1234_5678, F_XOR,  32'hCC99_E897, 1'b0);
    run("NOR",    32'hDEAD_BEEF, 32'h1234_5678, F_NOR,  32'h2142_0100, 1'b0);
    run("PASS_A", 32'hDEAD_BEEF, 32'h1234_5678, F_PASS, 32'hDEAD_BEEF, 1'b0);
    run("illegal FT", 32'hDEAD_BEEF, 32'h1234_5678, F_BAD, 32'h0000_0001, 1'b1);

    run("CLZ 0",        32'h0000_0000, 32'h0, F_CLZ, 32'd32, 1'b0);
    run("CLZ msb",      32'h8000_0000, 32'h0, F_CLZ, 32'd0,  1'b0);
    run("CLZ 1",        32'h0000_0001, 32'h0, F_CLZ, 32'd31, 1'b0);
    run("CLZ 00010000", 32'h0001_0000, 32'h0, F_CLZ, 32'd15, 1'b0);

    run("POP ones", 32'hFFFF_FFFF, 32'h0, F_POP, 32'd32, 1'b0);
    run("POP mix",  32'h1234_5678, 32'h0, F_POP, 32'd13, 1'b0);
    run("POP 0",    32'h0000_0000, 32'h0, F_POP, 32'd0,  1'b0);

    // Stall: result held, new request ignored until the result is taken.
    issue(32'hCAFE_F00D, 32'h0, F_PASS);
    wait_valid("stall op1", 32'hCAFE_F00D, 1'b0);
    @(posedge clk); #1;
    a = 32'hFFFF_0000; b = 32'h0F0F_0F0F; ft = F_AND; in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("stall S", {32'd0, s}, 64'h0000_0000_CAFE_F00D);
      check("stall in_ready", {63'd0, in_ready}, 64'd0);
      check("stall out_valid", {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("in_ready after take", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; ft = '0;
    wait_valid("stall op2", 32'h0F0F_0000, 1'b0);
    take();

    // Abort in the second RUN cycle of an illegal-code operation.
    issue(32'h1234_5678, 32'h0, F_BAD);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort in_ready", {63'd0, in_ready}, 64'd1);
    check("abort out_valid", {63'd0, out_valid}, 64'd0);
    check("abort err", {63'd0, err}, 64'd0);
    check("abort S holds", {32'd0, s}, 64'h0000_0000_0F0F_0000);
    repeat (8) @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    issue(32'h0000_FFFF, 32'h0, F_CLZ);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrun reset in_ready", {63'd0, in_ready}, 64'd1);
    check("midrun reset out_valid", {63'd0, out_valid}, 64'd0);
    check("midrun reset S", {32'd0, s}, 64'd0);
    check("midrun reset err", {63'd0, err}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run("POP after reset", 32'h1234_5678, 32'h0, F_POP, 32'd13, 1'b0);

    // Other geometries: 64/16 (four slices) and 32/32 (single slice).
    aux_op("CLZ 1",   64'h0000_0000_0000_0001, F_CLZ, 64'd63, 32'd31);
    aux_op("CLZ 0",   64'h0000_0000_0000_0000, F_CLZ, 64'd64, 32'd32);
    aux_op("CLZ b32", 64'h0000_0001_0000_0000, F_CLZ, 64'd31, 32'd32);
    aux_op("POP ones", 64'hFFFF_FFFF_FFFF_FFFF, F_POP, 64'd64, 32'd32);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic_seq_unit.md
# logic_seq_unit

Multi-cycle, parametrised successor to the ALU's combinational logic slice. It processes WIDTH-bit operands SLICE bits per cycle under a valid/ready handshake. It keeps the existing five bitwise functions and adds count-leading-zeros and population count. It sits beside the adder/shifter in the ALU and is selected by the low 4 bits of ALUFunc.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SLICE
- SLICE, 8, bits processed per RUN cycle; NSLICE = WIDTH/SLICE
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands/function presented
- in_ready  out  1  unit can accept (high only in IDLE)
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- FT  in  4  function code
- abort  in  1  synchronous cancel of current operation
- out_valid  out  1  S/err valid, held until taken
- out_ready  in  1  consumer takes result
- S  out  WIDTH  result
- err  out  1  FT was not a legal code

## Operation
- Function codes:
  - AND 4'b1000: A&B
  - OR 4'b1110: A|B
  - XOR 4'b0110: A^B
  - NOR 4'b0001: ~(A|B)
  - PASS_A 4'b1010: A
  - CLZ 4'b0011: leading zeros of A
  - POPCNT 4'b0101: number of ones in A
- Any other FT: S = 1 (zero-extended), err = 1; same latency as legal codes.
- A, B and FT are registered on acceptance (in_valid && in_ready). Later input changes have no effect.
- FSM:
  - IDLE: accept → RUN, slice index k = 0.
  - RUN: one slice per cycle, MSB slice first (bits WIDTH-1-k*SLICE downto WIDTH-(k+1)*SLICE). After slice NSLICE-1 → DONE.
  - DONE: out_valid = 1. Leaves to IDLE on out_ready.
- Bitwise ops write result slice k in place. S is assembled fully before out_valid.
- CLZ accumulator:
  - Adds the leading-zero count of each slice until the first slice containing a 1; later slices add nothing.
  - CLZ(0) = WIDTH.
- POPCNT accumulator sums per-slice popcounts.
- Counts are zero-extended into S. The accumulator is $clog2(WIDTH+1) bits wide and cannot overflow.
- err is registered on acceptance and presented with S.
- abort: from any state, the next edge goes to IDLE and clears out_valid and err. S holds its last value. abort beats out_ready and in_valid in the same cycle.

## Timing
- Reset values: FSM = IDLE, in_ready = 1, out_valid = 0, err = 0, S = 0, k = 0, accumulators = 0.
- Acceptance at edge t0. RUN covers cycles t0+1 … t0+NSLICE. out_valid rises at edge t0+NSLICE (NSLICE = 4 by default).
- out_valid && out_ready at edge t1 → IDLE. in_ready is high from t1 and the next acceptance is possible at t1+1.
- Minimum issue interval: NSLICE+2 cycles. There is no back-to-back acceptance in the DONE cycle.
- In DONE with out_ready low, S/err/out_valid stay stable indefinitely.
- in_valid while not IDLE is ignored (in_ready = 0). The producer must hold it.
- rst_n low at any time: all state returns to reset values immediately, including mid-RUN. No partial result appears after release.
- SLICE = WIDTH is legal: a single RUN cycle.

## Test plan
- Reset state: after rst_n release, check in_ready = 1, out_valid = 0, S = 0. Then A = 32'hF0F0_1234, B = 32'h0FF0_FFFF, FT = 1000 → S = 32'h00F0_1234 exactly 4 edges after acceptance, err = 0.
- Full bitwise sweep: one operand pair through OR, XOR, NOR and PASS_A → each result matches the bitwise reference. Also FT = 4'b1111 → S = 1, err = 1, same latency.
- CLZ boundaries:
  - A = 0 → 32
  - A = 32'h8000_0000 → 0
  - A = 32'h0000_0001 → 31
  - A = 32'h0001_0000 → 15 (zeros spanning slices, 1 inside slice 1)
- POPCNT: A = 32'hFFFF_FFFF → 32, A = 32'h1234_5678 → 13, A = 0 → 0.
- Handshake and stall:
  - out_ready held low 10 cycles → S stable and in_ready = 0 throughout; new in_valid ignored.
  - Raise out_ready → in_ready = 1 the following cycle. Second operation accepted and correct.
- Abort and reset: abort in RUN cycle 2 → IDLE next edge with out_valid never asserted. Then rst_n pulsed low mid-RUN → reset values immediately. A fresh POPCNT afterwards is correct. Repeat with WIDTH = 64, SLICE = 16: CLZ(64'h1) = 63.
